// File: rtl/pad_in_pkg.sv
// Shared constants, debounce state encoding and counter sizing for pad input capture.
// Latency: none (package only).
// Backpressure: none (package only).
package pad_in_pkg;

    localparam int unsigned DEF_WIDTH           = 4;
    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;

    typedef enum logic {
        DB_STABLE,
        DB_COUNTING
    } db_state_e;

    // One spare bit above what is needed to hold DEBOUNCE_CYCLES-1 keeps the count well clear of wrapping.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/pad_debounce_bit.sv
// One pad bit: INFF, synchronizer chain, debounce FSM, registered rise/fall pulses.
// Latency: level follows a stable pad change at edge 1+SYNC_STAGES+DEBOUNCE_CYCLES, counting the capture edge as 1.
// Backpressure: none; free-running every cycle.
module pad_debounce_bit
    import pad_in_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic pad_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic                   inff_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // Input flop holds no logic in front of it so it can sit in the IOB.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            inff_q <= RESET_LEVEL;
        end else begin
            inff_q <= pad_i;
        end
    end

    // Metastability settling chain behind the input flop.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], inff_q};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive mismatching cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        case (state_q)
            DB_STABLE: begin
                if (s != level_q) begin
                    if (CNT_LAST == '0) begin
                        level_d = s;
                    end else begin
                        state_d = DB_COUNTING;
                        cnt_d   = CW'(1);
                    end
                end
            end
            DB_COUNTING: begin
                if (s == level_q) begin
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    level_d = s;
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = DB_STABLE;
                cnt_d   = '0;
            end
        endcase
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
    end

    // Debounce state, accepted level and edge pulses; reset drops any count in progress.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= DB_STABLE;
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/pad_input_capture.sv
// Captures WIDTH async pad inputs, debounces them and keeps a change-event record for core logic.
// Latency: level at edge 1+SYNC_STAGES+DEBOUNCE_CYCLES; rise/fall with level; event record one cycle after the pulse.
// Backpressure: record held until event_ack; further changes merge into it and flag overflow on repeat bits.
module pad_input_capture
    import pad_in_pkg::*;
#(
    parameter int unsigned      WIDTH           = DEF_WIDTH,
    parameter int unsigned      SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned      DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             event_valid,
    output logic [WIDTH-1:0] event_mask,
    output logic [WIDTH-1:0] event_level,
    output logic             event_overflow,
    input  logic             event_ack
);

    logic [WIDTH-1:0] chg;
    logic             ev_valid_q, ev_valid_d;
    logic [WIDTH-1:0] ev_mask_q, ev_mask_d;
    logic [WIDTH-1:0] ev_level_q, ev_level_d;
    logic             ev_ovf_q, ev_ovf_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pad_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL[i])
        ) u_bit (
            .clk_i   (clk),
            .rst_n_i (rst_n),
            .pad_i   (pad_in[i]),
            .level_o (level[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i])
        );
    end

    assign chg = rise | fall;

    // Event record: load fresh when idle or being acked, otherwise merge; a bare ack empties it.
    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_mask_d  = ev_mask_q;
        ev_level_d = ev_level_q;
        ev_ovf_d   = ev_ovf_q;
        if (chg != '0) begin
            ev_level_d = level;
            if (!ev_valid_q || event_ack) begin
                ev_valid_d = 1'b1;
                ev_mask_d  = chg;
                ev_ovf_d   = 1'b0;
            end else begin
                ev_mask_d = ev_mask_q | chg;
                ev_ovf_d  = ev_ovf_q | (|(ev_mask_q & chg));
            end
        end else if (ev_valid_q && event_ack) begin
            ev_valid_d = 1'b0;
            ev_mask_d  = '0;
            ev_ovf_d   = 1'b0;
        end
    end

    // Event record registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ev_valid_q <= 1'b0;
            ev_mask_q  <= '0;
            ev_level_q <= RESET_LEVEL;
            ev_ovf_q   <= 1'b0;
        end else begin
            ev_valid_q <= ev_valid_d;
            ev_mask_q  <= ev_mask_d;
            ev_level_q <= ev_level_d;
            ev_ovf_q   <= ev_ovf_d;
        end
    end

    assign event_valid    = ev_valid_q;
    assign event_mask     = ev_mask_q;
    assign event_level    = ev_level_q;
    assign event_overflow = ev_ovf_q;

endmodule

// File: tb/tb_pad_input_capture.sv
// Bench for pad_input_capture: default instance plus a DEBOUNCE_CYCLES=1, SYNC_STAGES=3 instance.
// Latency: checks are made on the falling edge, away from the active edge.
// Backpressure: expected event records queue on stimulus and are compared when the record is acked.
module tb_pad_input_capture;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] pad_in, pad_in1;
    logic [3:0] level, rise, fall, event_mask, event_level;
    logic       event_valid, event_overflow, event_ack;
    logic [3:0] level1, rise1, fall1, event_mask1, event_level1;
    logic       event_valid1, event_overflow1, event_ack1;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] lvl;
        logic       ovf;
    } rec_t;

    rec_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [3:0] rise_acc, fall_acc;

    always #5 clk = ~clk;

    pad_input_capture dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pad_in         (pad_in),
        .level          (level),
        .rise           (rise),
        .fall           (fall),
        .event_valid    (event_valid),
        .event_mask     (event_mask),
        .event_level    (event_level),
        .event_overflow (event_overflow),
        .event_ack      (event_ack)
    );

    pad_input_capture #(
        .WIDTH           (4),
        .SYNC_STAGES     (3),
        .DEBOUNCE_CYCLES (1),
        .RESET_LEVEL     (4'b0000)
    ) dut1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .pad_in         (pad_in1),
        .level          (level1),
        .rise           (rise1),
        .fall           (fall1),
        .event_valid    (event_valid1),
        .event_mask     (event_mask1),
        .event_level    (event_level1),
        .event_overflow (event_overflow1),
        .event_ack      (event_ack1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n cycles, landing on falling edges, and remember any pulses seen.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rise_acc = rise_acc | rise;
            fall_acc = fall_acc | fall;
        end
    endtask

    task automatic compare_front(input string tag);
        rec_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got record mask %0h", tag, event_mask);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, 32'(event_valid), 32'd1);
            check({tag, "_mask"},  32'(event_mask),  32'(e.mask));
            check({tag, "_level"}, 32'(event_level), 32'(e.lvl));
            check({tag, "_ovf"},   32'(event_overflow), 32'(e.ovf));
        end
    endtask

    task automatic ack_record(input string tag);
        compare_front(tag);
        event_ack = 1'b1;
        step(1);
        event_ack = 1'b0;
        check({tag, "_ack_valid"}, 32'(event_valid), 32'd0);
        check({tag, "_ack_mask"},  32'(event_mask),  32'd0);
        check({tag, "_ack_ovf"},   32'(event_overflow), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        pad_in     = 4'hF;
        pad_in1    = 4'h0;
        event_ack  = 1'b0;
        event_ack1 = 1'b0;
        rise_acc   = '0;
        fall_acc   = '0;

        // Reset with all pads high: nothing may move while reset is held.
        step(3);
        check("rst_level",    32'(level),       32'h0);
        check("rst_no_rise",  32'(rise_acc),    32'h0);
        check("rst_valid",    32'(event_valid), 32'h0);
        check("rst_mask",     32'(event_mask),  32'h0);
        check("rst_ev_level", 32'(event_level), 32'h0);
        check("rst_level1",   32'(level1),      32'h0);

        // Release: first sampling edge is cycle 1, level appears at cycle 7.
        exp_q.push_back('{mask: 4'hF, lvl: 4'hF, ovf: 1'b0});
        rst_n = 1'b1;
        step(6);
        check("lat_before_level", 32'(level), 32'h0);
        check("lat_before_rise",  32'(rise_acc), 32'h0);
        step(1);
        check("lat_level", 32'(level), 32'hF);
        check("lat_rise",  32'(rise),  32'hF);
        step(1);
        check("lat_rise_drop", 32'(rise), 32'h0);
        ack_record("rst_rec");

        // Back to all-low via reset.
        rst_n  = 1'b0;
        pad_in = 4'h0;
        step(2);
        rst_n = 1'b1;
        step(4);
        check("rst2_level", 32'(level), 32'h0);

        // Glitch of three synchronized cycles on bit 0 is rejected.
        rise_acc = '0;
        pad_in   = 4'b0001;
        step(3);
        pad_in = 4'b0000;
        step(12);
        check("glitch_level", 32'(level),       32'h0);
        check("glitch_rise",  32'(rise_acc),    32'h0);
        check("glitch_event", 32'(event_valid), 32'h0);

        // Held high: accepted, then two more changes merge into the same record.
        exp_q.push_back('{mask: 4'b0101, lvl: 4'b0100, ovf: 1'b1});
        pad_in = 4'b0001;
        step(6);
        check("hold_before", 32'(level), 32'h0);
        step(1);
        check("hold_level", 32'(level), 32'h1);
        check("hold_rise",  32'(rise),  32'h1);
        step(1);
        check("hold_rise_drop", 32'(rise),        32'h0);
        check("hold_valid",     32'(event_valid), 32'h1);
        check("hold_mask",      32'(event_mask),  32'h1);
        check("hold_ev_level",  32'(event_level), 32'h1);

        pad_in = 4'b0101;
        step(7);
        check("acc_rise2", 32'(rise), 32'b0100);
        step(1);
        check("acc_mask1",     32'(event_mask),     32'b0101);
        check("acc_ev_level1", 32'(event_level),    32'b0101);
        check("acc_ovf1",      32'(event_overflow), 32'h0);

        pad_in = 4'b0100;
        step(7);
        check("acc_fall0", 32'(fall), 32'b0001);
        step(1);
        ack_record("accum");

        // Simultaneous ack and a fresh change hands over and reloads.
        exp_q.push_back('{mask: 4'b1000, lvl: 4'b1100, ovf: 1'b0});
        pad_in = 4'b1100;
        step(9);
        ack_record("b3_rise");

        exp_q.push_back('{mask: 4'b0001, lvl: 4'b1101, ovf: 1'b0});
        exp_q.push_back('{mask: 4'b1000, lvl: 4'b0101, ovf: 1'b0});
        pad_in = 4'b1101;
        step(9);
        pad_in = 4'b0101;
        step(7);
        check("simul_fall3", 32'(fall), 32'b1000);
        compare_front("simul_old");
        event_ack = 1'b1;
        step(1);
        event_ack = 1'b0;
        check("simul_valid", 32'(event_valid),    32'h1);
        check("simul_mask",  32'(event_mask),     32'b1000);
        check("simul_ovf",   32'(event_overflow), 32'h0);
        ack_record("simul");

        // Reset while bit 1 is part-way through its debounce count.
        pad_in = 4'b0111;
        step(5);
        rise_acc = '0;
        fall_acc = '0;
        rst_n    = 1'b0;
        pad_in   = 4'b0000;
        step(1);
        rst_n = 1'b1;
        check("mid_rst_level", 32'(level),       32'h0);
        check("mid_rst_rise",  32'(rise),        32'h0);
        check("mid_rst_fall",  32'(fall),        32'h0);
        check("mid_rst_valid", 32'(event_valid), 32'h0);
        check("mid_rst_mask",  32'(event_mask),  32'h0);
        step(12);
        check("mid_rst_no_rise", 32'(rise_acc), 32'h0);
        check("mid_rst_no_fall", 32'(fall_acc), 32'h0);
        check("mid_rst_settled", 32'(level),    32'h0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        // Unfiltered instance with three sync stages: step at cycle 5, one-cycle pulse passes through.
        pad_in1 = 4'b0001;
        step(4);
        check("nf_before", 32'(level1), 32'h0);
        step(1);
        check("nf_level", 32'(level1), 32'h1);
        check("nf_rise",  32'(rise1),  32'h1);

        pad_in1 = 4'b0011;
        step(1);
        pad_in1 = 4'b0001;
        step(3);
        check("nf_pulse_before", 32'(level1), 32'b0001);
        step(1);
        check("nf_pulse_rise",  32'(rise1),  32'b0010);
        check("nf_pulse_level", 32'(level1), 32'b0011);
        step(1);
        check("nf_pulse_fall",     32'(fall1),  32'b0010);
        check("nf_pulse_rise_off", 32'(rise1),  32'h0);
        check("nf_pulse_level2",   32'(level1), 32'b0001);
        step(1);
        check("nf_ev_valid", 32'(event_valid1),    32'h1);
        check("nf_ev_mask",  32'(event_mask1),     32'b0011);
        check("nf_ev_ovf",   32'(event_overflow1), 32'h1);
        check("nf_ev_level", 32'(event_level1),    32'b0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
